tokenizer_stream: RTL and testbench

Parametrised tokenizer that walks a nul-terminated ASCII string in AXI memory through the `char_rstream` byte reader and delivers each token on a valid/ready output port.
- Tokens are separated by spaces and/or a single comma.
- `'` or `"` quoting keeps embedded spaces and commas inside a token.
- Adds output backpressure, per-token length/index/flags, truncation of over-long tokens, a token-count limit and end-of-run status.
- Sits between `char_rstream` and command-parsing logic such as `strtoul`.

---
 rtl/tokenizer_stream.sv | 253 +++++++++++++++++++++++++
 tb/tb_tokenizer_stream.sv | 472 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tokenizer_stream.sv
// tokenizer_stream
// Walks a nul-terminated ASCII string through the char_rstream byte reader
// and hands out space/comma separated tokens on a valid/ready port. Tokens
// may be wrapped in ' or " to keep embedded spaces and commas. Each token
// carries its length, run index, quoted and truncated flags; a run ends with
// a one-cycle DONE plus the token count and sticky status bits.
module tokenizer_stream #(
    parameter int M_AXI_ADDR_WIDTH = 32,
    parameter int TOKEN_WIDTH      = 256,
    parameter int MAX_TOKENS       = 16,
    localparam int TOKEN_BYTES     = TOKEN_WIDTH / 8,
    localparam int LEN_W           = $clog2(TOKEN_BYTES + 1),
    localparam int CNT_W           = $clog2(MAX_TOKENS + 1)
) (
    input  logic                        AXI_ACLK,
    input  logic                        AXI_RESET,
    input  logic                        START,
    input  logic [M_AXI_ADDR_WIDTH-1:0] STR_ADDR,
    output logic [1:0]                  ISTREAM_CMD,
    output logic [M_AXI_ADDR_WIDTH-1:0] ISTREAM_ADDR,
    input  logic                        ISTREAM_VALID,
    input  logic [7:0]                  ISTREAM_DATA,
    output logic [TOKEN_WIDTH-1:0]      TOKEN_DATA,
    output logic [LEN_W-1:0]            TOKEN_LEN,
    output logic [CNT_W-1:0]            TOKEN_INDEX,
    output logic                        TOKEN_QUOTED,
    output logic                        TOKEN_TRUNC,
    output logic                        TOKEN_VALID,
    input  logic                        TOKEN_READY,
    output logic                        BUSY,
    output logic                        DONE,
    output logic [CNT_W-1:0]            TOKEN_COUNT,
    output logic [1:0]                  STATUS
);

    localparam logic [1:0] CMD_NONE  = 2'd0;
    localparam logic [1:0] CMD_START = 2'd1;
    localparam logic [1:0] CMD_NEXT  = 2'd2;

    localparam logic [7:0] CHR_NUL   = 8'h00;
    localparam logic [7:0] CHR_SPACE = 8'h20;
    localparam logic [7:0] CHR_DQ    = 8'h22;
    localparam logic [7:0] CHR_SQ    = 8'h27;
    localparam logic [7:0] CHR_COMMA = 8'h2C;

    typedef enum logic [2:0] {
        Idle,
        StartNewToken,
        ParseToken,
        Emit,
        SkipTrailingSpaces,
        SkipTrailingComma,
        Complete
    } stateT;

    stateT                       state_q, state_d;
    logic [1:0]                  cmd_q, cmd_d;
    logic [M_AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [TOKEN_WIDTH-1:0]      tokenData_q, tokenData_d;
    logic [LEN_W-1:0]            tokenLen_q, tokenLen_d;
    logic                        tokenTrunc_q, tokenTrunc_d;
    logic                        tokenQuoted_q, tokenQuoted_d;
    logic [7:0]                  quoteChar_q, quoteChar_d;
    logic                        tokenValid_q, tokenValid_d;
    logic                        busy_q, busy_d;
    logic                        done_q, done_d;
    logic [CNT_W-1:0]            count_q, count_d;
    logic [1:0]                  status_q, status_d;

    logic                        byteAvail;
    logic                        appendByte;

    // The stream's VALID can still show the old byte during our own command
    // pulse, so a byte is only trusted when no command is in flight.
    assign byteAvail = ISTREAM_VALID && (cmd_q == CMD_NONE);

    // Next-state logic: walk the string one byte at a time and build tokens.
    always_comb begin
        state_d       = state_q;
        cmd_d         = CMD_NONE;
        addr_d        = addr_q;
        tokenData_d   = tokenData_q;
        tokenLen_d    = tokenLen_q;
        tokenTrunc_d  = tokenTrunc_q;
        tokenQuoted_d = tokenQuoted_q;
        quoteChar_d   = quoteChar_q;
        tokenValid_d  = tokenValid_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        count_d       = count_q;
        status_d      = status_q;
        appendByte    = 1'b0;

        case (state_q)
            Idle: begin
                if (START) begin
                    addr_d   = STR_ADDR;
                    cmd_d    = CMD_START;
                    count_d  = '0;
                    status_d = 2'b00;
                    busy_d   = 1'b1;
                    state_d  = StartNewToken;
                end
            end

            StartNewToken: begin
                if (byteAvail) begin
                    if (ISTREAM_DATA == CHR_SPACE) begin
                        cmd_d = CMD_NEXT;
                    end else if (ISTREAM_DATA == CHR_NUL) begin
                        state_d = Complete;
                    end else if (count_q == CNT_W'(MAX_TOKENS)) begin
                        status_d[1] = 1'b1;
                        state_d     = Complete;
                    end else begin
                        tokenData_d  = '0;
                        tokenLen_d   = '0;
                        tokenTrunc_d = 1'b0;
                        state_d      = ParseToken;
                        if ((ISTREAM_DATA == CHR_DQ) || (ISTREAM_DATA == CHR_SQ)) begin
                            quoteChar_d   = ISTREAM_DATA;
                            tokenQuoted_d = 1'b1;
                            cmd_d         = CMD_NEXT;
                        end else begin
                            quoteChar_d   = CHR_NUL;
                            tokenQuoted_d = 1'b0;
                        end
                    end
                end
            end

            ParseToken: begin
                if (byteAvail) begin
                    if (tokenQuoted_q) begin
                        if (ISTREAM_DATA == quoteChar_q) begin
                            cmd_d   = CMD_NEXT;
                            state_d = Emit;
                        end else if (ISTREAM_DATA == CHR_NUL) begin
                            status_d[0] = 1'b1;
                            state_d     = Emit;
                        end else begin
                            appendByte = 1'b1;
                        end
                    end else begin
                        if ((ISTREAM_DATA == CHR_SPACE) || (ISTREAM_DATA == CHR_COMMA) ||
                            (ISTREAM_DATA == CHR_NUL)) begin
                            state_d = Emit;
                        end else begin
                            appendByte = 1'b1;
                        end
                    end
                end
            end

            Emit: begin
                if (!tokenValid_q) begin
                    tokenValid_d = 1'b1;
                end else if (TOKEN_READY) begin
                    tokenValid_d = 1'b0;
                    count_d      = count_q + CNT_W'(1);
                    state_d      = SkipTrailingSpaces;
                end
            end

            SkipTrailingSpaces: begin
                if (byteAvail) begin
                    if (ISTREAM_DATA == CHR_SPACE) begin
                        cmd_d = CMD_NEXT;
                    end else begin
                        state_d = SkipTrailingComma;
                    end
                end
            end

            SkipTrailingComma: begin
                if (byteAvail) begin
                    if (ISTREAM_DATA == CHR_COMMA) begin
                        cmd_d = CMD_NEXT;
                    end
                    state_d = StartNewToken;
                end
            end

            Complete: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = Idle;
            end

            default: begin
                state_d = Idle;
            end
        endcase

        // Keep the first TOKEN_BYTES characters; anything beyond only marks truncation.
        if (appendByte) begin
            cmd_d = CMD_NEXT;
            if (tokenLen_q != LEN_W'(TOKEN_BYTES)) begin
                tokenData_d = (tokenData_q << 8) | TOKEN_WIDTH'(ISTREAM_DATA);
                tokenLen_d  = tokenLen_q + LEN_W'(1);
            end else begin
                tokenTrunc_d = 1'b1;
            end
        end
    end

    // State and output registers; reset abandons any run and zeroes every output.
    always_ff @(posedge AXI_ACLK) begin
        if (AXI_RESET) begin
            state_q       <= Idle;
            cmd_q         <= CMD_NONE;
            addr_q        <= '0;
            tokenData_q   <= '0;
            tokenLen_q    <= '0;
            tokenTrunc_q  <= 1'b0;
            tokenQuoted_q <= 1'b0;
            quoteChar_q   <= 8'h00;
            tokenValid_q  <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            count_q       <= '0;
            status_q      <= 2'b00;
        end else begin
            state_q       <= state_d;
            cmd_q         <= cmd_d;
            addr_q        <= addr_d;
            tokenData_q   <= tokenData_d;
            tokenLen_q    <= tokenLen_d;
            tokenTrunc_q  <= tokenTrunc_d;
            tokenQuoted_q <= tokenQuoted_d;
            quoteChar_q   <= quoteChar_d;
            tokenValid_q  <= tokenValid_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            count_q       <= count_d;
            status_q      <= status_d;
        end
    end

    assign ISTREAM_CMD  = cmd_q;
    assign ISTREAM_ADDR = addr_q;
    assign TOKEN_DATA   = tokenData_q;
    assign TOKEN_LEN    = tokenLen_q;
    assign TOKEN_INDEX  = count_q;
    assign TOKEN_QUOTED = tokenQuoted_q;
    assign TOKEN_TRUNC  = tokenTrunc_q;
    assign TOKEN_VALID  = tokenValid_q;
    assign BUSY         = busy_q;
    assign DONE         = done_q;
    assign TOKEN_COUNT  = count_q;
    assign STATUS       = status_q;

endmodule

// File: tb/tb_tokenizer_stream.sv
// tb_tokenizer_stream
// Drives tokenizer_stream with a small char_rstream memory model (random
// latency) and compares every emitted token, and the end-of-run summary,
// against a software-style tokenizer applied to the same string.
module tb_tokenizer_stream;

    localparam int AW       = 32;
    localparam int TW       = 32;
    localparam int MT       = 3;
    localparam int TB_BYTES = TW / 8;
    localparam int LW       = $clog2(TB_BYTES + 1);
    localparam int CW       = $clog2(MT + 1);

    typedef struct {
        logic [TW-1:0] data;
        int            len;
        int            idx;
        bit            quoted;
        bit            trunc;
    } tokT;

    logic          clk       = 1'b0;
    logic          reset     = 1'b1;
    logic          start     = 1'b0;
    logic [AW-1:0] strAddr   = '0;
    logic [1:0]    cmd;
    logic [AW-1:0] istrAddr;
    logic          istrValid = 1'b0;
    logic [7:0]    istrData  = 8'h00;
    logic [TW-1:0] tokData;
    logic [LW-1:0] tokLen;
    logic [CW-1:0] tokIdx;
    logic          tokQuoted;
    logic          tokTrunc;
    logic          tokValid;
    logic          tokReady  = 1'b0;
    logic          busy;
    logic          done;
    logic [CW-1:0] tokCount;
    logic [1:0]    status;

    int errors = 0;
    int checks = 0;

    logic [7:0] mem [0:255];
    logic [7:0] strQ [$];
    tokT        expQ [$];
    int         expCount = 0;
    logic [1:0] expStatus = 2'b00;

    bit            checkEn   = 1'b0;
    bit            doneSeen  = 1'b0;
    logic [TW-1:0] lastData  = '0;
    int            lastLen   = 0;
    bit            lastQuoted = 1'b0;
    bit            lastTrunc = 1'b0;
    logic [CW-1:0] dutCount  = '0;
    logic [1:0]    dutStatus = 2'b00;
    int            readyMode = 0;

    logic [1:0]    seenCmd  = 2'd0;
    logic [AW-1:0] seenAddr = '0;
    int            ptr      = 0;
    int            waitCnt  = -1;

    tokenizer_stream #(
        .M_AXI_ADDR_WIDTH(AW),
        .TOKEN_WIDTH     (TW),
        .MAX_TOKENS      (MT)
    ) dut (
        .AXI_ACLK     (clk),
        .AXI_RESET    (reset),
        .START        (start),
        .STR_ADDR     (strAddr),
        .ISTREAM_CMD  (cmd),
        .ISTREAM_ADDR (istrAddr),
        .ISTREAM_VALID(istrValid),
        .ISTREAM_DATA (istrData),
        .TOKEN_DATA   (tokData),
        .TOKEN_LEN    (tokLen),
        .TOKEN_INDEX  (tokIdx),
        .TOKEN_QUOTED (tokQuoted),
        .TOKEN_TRUNC  (tokTrunc),
        .TOKEN_VALID  (tokValid),
        .TOKEN_READY  (tokReady),
        .BUSY         (busy),
        .DONE         (done),
        .TOKEN_COUNT  (tokCount),
        .STATUS       (status)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Capture the command mid-cycle so the stream reacts to it on the next edge.
    always @(negedge clk) begin
        seenCmd  = cmd;
        seenAddr = istrAddr;
    end

    // char_rstream stand-in: a command drops VALID, the byte returns after a random delay.
    always @(posedge clk) begin
        #1;
        if (reset) begin
            istrValid = 1'b0;
            waitCnt   = -1;
        end else if (seenCmd == 2'd1) begin
            ptr       = int'(seenAddr[7:0]);
            istrValid = 1'b0;
            waitCnt   = int'($urandom_range(0, 2));
        end else if (seenCmd == 2'd2) begin
            ptr       = (ptr + 1) % 256;
            istrValid = 1'b0;
            waitCnt   = int'($urandom_range(0, 2));
        end else if (waitCnt > 0) begin
            waitCnt--;
        end else if (waitCnt == 0) begin
            istrValid = 1'b1;
            istrData  = mem[ptr];
            waitCnt   = -1;
        end
        if (!istrValid) istrData = 8'($urandom);
    end

    // Output backpressure: always ready, random, or held off.
    always @(posedge clk) begin
        #1;
        case (readyMode)
            0:       tokReady = 1'b1;
            1:       tokReady = 1'($urandom_range(0, 1));
            default: tokReady = 1'b0;
        endcase
    end

    // Compare every offered token and every end-of-run summary against the model.
    always @(negedge clk) begin
        if (checkEn && !reset) begin
            if (tokValid) begin
                checkOutput("cmdQuietWhileValid", 64'(cmd), 64'd0);
                if (expQ.size() == 0) begin
                    checkOutput("unexpectedToken", 64'(tokValid), 64'd0);
                end else begin
                    checkOutput("tokData", 64'(tokData), 64'(expQ[0].data));
                    checkOutput("tokLen", 64'(tokLen), 64'(expQ[0].len));
                    checkOutput("tokIndex", 64'(tokIdx), 64'(expQ[0].idx));
                    checkOutput("tokQuoted", 64'(tokQuoted), 64'(expQ[0].quoted));
                    checkOutput("tokTrunc", 64'(tokTrunc), 64'(expQ[0].trunc));
                    if (tokReady) begin
                        lastData   = tokData;
                        lastLen    = int'(tokLen);
                        lastQuoted = tokQuoted;
                        lastTrunc  = tokTrunc;
                        void'(expQ.pop_front());
                    end
                end
            end
            if (done) begin
                checkOutput("doneOnce", 64'(doneSeen), 64'd0);
                checkOutput("doneCount", 64'(tokCount), 64'(expCount));
                checkOutput("doneStatus", 64'(status), 64'(expStatus));
                checkOutput("doneBusyLow", 64'(busy), 64'd0);
                checkOutput("doneAllTokens", 64'(expQ.size()), 64'd0);
                dutCount  = tokCount;
                dutStatus = status;
                doneSeen  = 1'b1;
            end
        end
    end

    function automatic logic [7:0] at(input int p);
        return (p < strQ.size()) ? strQ[p] : 8'h00;
    endfunction

    // Software tokenizer: skip spaces, read one token, skip spaces and one comma.
    task automatic buildModel();
        int         p = 0;
        int         n = 0;
        bit         finished = 1'b0;
        bit         isQ;
        bit         endTok;
        logic [7:0] qc;
        logic [7:0] c;
        logic [7:0] chars [$];
        tokT        t;
        expQ.delete();
        expStatus = 2'b00;
        while (!finished) begin
            while (at(p) == 8'h20) p++;
            if (at(p) == 8'h00) begin
                finished = 1'b1;
            end else if (n == MT) begin
                expStatus[1] = 1'b1;
                finished     = 1'b1;
            end else begin
                qc  = at(p);
                isQ = (qc == 8'h22) || (qc == 8'h27);
                if (isQ) p++;
                chars.delete();
                endTok = 1'b0;
                while (!endTok) begin
                    c = at(p);
                    if (isQ && c == qc) begin
                        p++;
                        endTok = 1'b1;
                    end else if (isQ && c == 8'h00) begin
                        expStatus[0] = 1'b1;
                        endTok       = 1'b1;
                    end else if (!isQ && (c == 8'h20 || c == 8'h2C || c == 8'h00)) begin
                        endTok = 1'b1;
                    end else begin
                        chars.push_back(c);
                        p++;
                    end
                end
                t.len    = (chars.size() > TB_BYTES) ? TB_BYTES : chars.size();
                t.trunc  = chars.size() > TB_BYTES;
                t.data   = '0;
                for (int i = 0; i < t.len; i++) t.data = (t.data << 8) | TW'(chars[i]);
                t.idx    = n;
                t.quoted = isQ;
                expQ.push_back(t);
                n++;
                while (at(p) == 8'h20) p++;
                if (at(p) == 8'h2C) p++;
            end
        end
        expCount = n;
    endtask

    task automatic setString(input string s);
        strQ.delete();
        for (int i = 0; i < s.len(); i++) strQ.push_back(8'(s[i]));
        strQ.push_back(8'h00);
    endtask

    task automatic loadImage(input int base);
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < strQ.size(); i++) mem[(base + i) % 256] = strQ[i];
        buildModel();
    endtask

    task automatic applyStimulus(input logic [AW-1:0] addr);
        @(posedge clk);
        #1;
        start   = 1'b1;
        strAddr = addr;
        @(posedge clk);
        #1;
        start   = 1'b0;
    endtask

    task automatic startRun(input int base);
        doneSeen = 1'b0;
        checkEn  = 1'b1;
        applyStimulus(AW'(base));
        @(negedge clk);
        checkOutput("startCmd", 64'(cmd), 64'd1);
        checkOutput("startBusy", 64'(busy), 64'd1);
        checkOutput("startAddr", 64'(istrAddr), 64'(base));
    endtask

    task automatic waitDone();
        int n = 0;
        while (!doneSeen && n < 3000) begin
            @(posedge clk);
            n++;
        end
        checkOutput("doneReached", 64'(doneSeen), 64'd1);
        if (!doneSeen) begin
            checkEn = 1'b0;
            @(posedge clk);
            #1;
            reset = 1'b1;
            @(posedge clk);
            #1;
            reset = 1'b0;
            expQ.delete();
        end
        @(posedge clk);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "Data"}, 64'(tokData), 64'd0);
        checkOutput({tag, "Len"}, 64'(tokLen), 64'd0);
        checkOutput({tag, "Index"}, 64'(tokIdx), 64'd0);
        checkOutput({tag, "Flags"}, 64'({tokQuoted, tokTrunc, tokValid}), 64'd0);
        checkOutput({tag, "Cmd"}, 64'(cmd), 64'd0);
        checkOutput({tag, "Addr"}, 64'(istrAddr), 64'd0);
        checkOutput({tag, "BusyDone"}, 64'({busy, done}), 64'd0);
        checkOutput({tag, "Count"}, 64'(tokCount), 64'd0);
        checkOutput({tag, "Status"}, 64'(status), 64'd0);
    endtask

    // Hard stop if the sequence itself wedges.
    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed cases, backpressure, ignored START, mid-run reset, then random strings.
    initial begin
        int            pulses;
        int            guard;
        int            len;
        int            r;
        logic [TW-1:0] snapData;

        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkAllZero("reset");
        @(posedge clk);
        #1;
        reset = 1'b0;

        setString("  abc, def");
        loadImage(16);
        checkOutput("modelAbcCount", 64'(expCount), 64'd2);
        checkOutput("modelAbcTok0", 64'(expQ[0].data), 64'h616263);
        checkOutput("modelAbcTok1Idx", 64'(expQ[1].idx), 64'd1);
        startRun(16);
        waitDone();
        checkOutput("abcLastData", 64'(lastData), 64'h646566);
        checkOutput("abcLastLen", 64'(lastLen), 64'd3);
        checkOutput("abcCount", 64'(dutCount), 64'd2);
        checkOutput("abcStatus", 64'(dutStatus), 64'd0);

        setString("\"a b\",'x,y'");
        loadImage(40);
        checkOutput("modelQuoteTok0", 64'(expQ[0].data), 64'h612062);
        checkOutput("modelQuoteFlag", 64'(expQ[0].quoted), 64'd1);
        startRun(40);
        waitDone();
        checkOutput("quoteLastData", 64'(lastData), 64'h782C79);
        checkOutput("quoteLastQuoted", 64'(lastQuoted), 64'd1);
        checkOutput("quoteCount", 64'(dutCount), 64'd2);

        setString(",,");
        loadImage(70);
        checkOutput("modelCommaCount", 64'(expCount), 64'd2);
        checkOutput("modelCommaLen", 64'(expQ[1].len), 64'd0);
        startRun(70);
        waitDone();
        checkOutput("commaLastLen", 64'(lastLen), 64'd0);
        checkOutput("commaLastData", 64'(lastData), 64'd0);
        checkOutput("commaCount", 64'(dutCount), 64'd2);

        setString("abcdef");
        loadImage(90);
        checkOutput("modelTruncData", 64'(expQ[0].data), 64'h61626364);
        checkOutput("modelTruncFlag", 64'(expQ[0].trunc), 64'd1);
        startRun(90);
        waitDone();
        checkOutput("truncLastData", 64'(lastData), 64'h61626364);
        checkOutput("truncLastLen", 64'(lastLen), 64'd4);
        checkOutput("truncLastFlag", 64'(lastTrunc), 64'd1);

        setString("\"ab");
        loadImage(120);
        checkOutput("modelUntermStatus", 64'(expStatus), 64'd1);
        startRun(120);
        waitDone();
        checkOutput("untermLastData", 64'(lastData), 64'h6162);
        checkOutput("untermStatus", 64'(dutStatus), 64'd1);
        checkOutput("untermCount", 64'(dutCount), 64'd1);

        setString("a b c d");
        loadImage(150);
        checkOutput("modelLimitStatus", 64'(expStatus), 64'd2);
        startRun(150);
        waitDone();
        checkOutput("limitLastData", 64'(lastData), 64'h63);
        checkOutput("limitStatus", 64'(dutStatus), 64'd2);
        checkOutput("limitCount", 64'(dutCount), 64'd3);

        readyMode = 2;
        setString("hello world");
        loadImage(10);
        startRun(10);
        guard = 0;
        while (!tokValid && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("holdValidSeen", 64'(tokValid), 64'd1);
        snapData = tokData;
        checkOutput("holdFirstData", 64'(snapData), 64'h68656C6C);
        repeat (10) begin
            @(negedge clk);
            checkOutput("holdValid", 64'(tokValid), 64'd1);
            checkOutput("holdData", 64'(tokData), 64'(snapData));
            checkOutput("holdNoCmd", 64'(cmd), 64'd0);
        end
        readyMode = 0;
        waitDone();
        checkOutput("holdCount", 64'(dutCount), 64'd2);

        setString("ab cd");
        loadImage(30);
        startRun(30);
        repeat (3) @(posedge clk);
        applyStimulus(AW'(200));
        @(negedge clk);
        checkOutput("ignoredStartAddr", 64'(istrAddr), 64'd30);
        checkOutput("ignoredStartBusy", 64'(busy), 64'd1);
        waitDone();
        checkOutput("ignoredStartCount", 64'(dutCount), 64'd2);

        setString("abcdefgh ijk");
        loadImage(60);
        startRun(60);
        pulses = 0;
        guard  = 0;
        while (pulses < 3 && guard < 300) begin
            @(negedge clk);
            if (cmd == 2'd2) pulses++;
            guard++;
        end
        checkOutput("midParseReached", 64'(pulses), 64'd3);
        checkEn = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkAllZero("midReset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        expQ.delete();

        setString("xy,z");
        loadImage(100);
        startRun(100);
        waitDone();
        checkOutput("afterResetCount", 64'(dutCount), 64'd2);
        checkOutput("afterResetLast", 64'(lastData), 64'h7A);

        readyMode = 1;
        for (int iter = 0; iter < 40; iter++) begin
            strQ.delete();
            len = int'($urandom_range(0, 18));
            for (int k = 0; k < len; k++) begin
                r = int'($urandom_range(0, 15));
                if (r <= 6)       strQ.push_back(8'h61 + 8'(r));
                else if (r <= 9)  strQ.push_back(8'h20);
                else if (r <= 11) strQ.push_back(8'h2C);
                else if (r == 12) strQ.push_back(8'h22);
                else if (r == 13) strQ.push_back(8'h27);
                else              strQ.push_back(8'h7A);
            end
            strQ.push_back(8'h00);
            r = int'($urandom_range(0, 200));
            loadImage(r);
            startRun(r);
            waitDone();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
